// File: rtl/mul_shift_add_8bit_if.sv
// Handshake and data bundle between the CPU datapath and the shift-add multiplier.
interface mul_shift_add_8bit_if;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/ripple_adder_8bit.sv
// 8-bit ripple-carry adder shared by the datapath; one full-adder cell per bit.
module ripple_adder_8bit (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       carry_i,
    output logic [7:0] sum_o,
    output logic       carry_o
);
    logic carry;

    always_comb begin
        carry = carry_i;
        sum_o = '0;
        for (int i = 0; i < 8; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
            carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
        end
        carry_o = carry;
    end
endmodule

// File: rtl/mul_shift_add_8bit.sv
// Sequential 8x8 unsigned multiplier: one shift-and-add iteration per cycle through a
// single ripple adder, 8 iterations per product, start/busy/done handshake.
module mul_shift_add_8bit (
    input logic                  clk,
    input logic                  rst,
    mul_shift_add_8bit_if.slave  bus_io
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q;
    logic [7:0]  mcand_q;
    logic [7:0]  hi_q;
    logic [7:0]  lo_q;
    logic [3:0]  cnt_q;
    logic [15:0] product_q;

    logic [7:0]  addend;
    logic [7:0]  sum;
    logic        carry_out;
    logic [7:0]  hi_d;
    logic [7:0]  lo_d;

    ripple_adder_8bit u_adder (
        .a_i     (hi_q),
        .b_i     (addend),
        .carry_i (1'b0),
        .sum_o   (sum),
        .carry_o (carry_out)
    );

    // The working register's top bit is always zero after the shift, so it is not stored.
    always_comb begin
        addend = lo_q[0] ? mcand_q : 8'h00;
        hi_d   = {carry_out, sum[7:1]};
        lo_d   = {sum[0], lo_q[7:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (bus_io.start) begin
                        mcand_q <= bus_io.a;
                        hi_q    <= '0;
                        lo_q    <= bus_io.b;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        product_q <= {hi_d, lo_d};
                        state_q   <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.busy    = (state_q == StRun);
    assign bus_io.done    = (state_q == StDone);
    assign bus_io.product = product_q;
endmodule

// File: tb/tb_mul_shift_add_8bit.sv
// Self-checking bench for mul_shift_add_8bit: cycle-level behavioural model plus directed
// and randomized multiplies.
module tb_mul_shift_add_8bit;
    logic clk;
    logic rst;
    mul_shift_add_8bit_if bus ();

    mul_shift_add_8bit dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_dones = 0;
    int dut_dones = 0;
    bit chk_en = 1'b0;

    // Model: cycles remaining until completion, the pending product, and visible outputs.
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [15:0] m_pend = '0;
    logic [15:0] m_prod = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_prod <= '0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) m_prod <= m_pend;
        end else begin
            m_done <= 1'b0;
            if (bus.start) begin
                m_left <= 8;
                m_pend <= 16'(bus.a) * 16'(bus.b);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", int'(bus.busy), int'(m_left > 0));
            chk("done", int'(bus.done), int'(m_done));
            chk("product", int'(bus.product), int'(m_prod));
            if (bus.done) dut_dones++;
        end
    end

    // Called at a negedge; returns at the negedge where done is observed.
    task automatic do_mul(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp,
                          input string name);
        int n;
        int busy_n;
        bit got;
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        n = 0;
        busy_n = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            if (bus.busy) busy_n++;
            if (bus.done) got = 1'b1;
            bus.start = (n == 3);
        end
        bus.start = 1'b0;
        chk({name, "_latency"}, n, 9);
        chk({name, "_busy_cycles"}, busy_n, 8);
        chk({name, "_result"}, int'(bus.product), int'(exp));
        exp_dones++;
    endtask

    initial begin
        int n;
        int cnt;
        logic [7:0] x;
        logic [7:0] y;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("reset_product", int'(bus.product), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        repeat (2) @(negedge clk);

        do_mul(8'd0, 8'd0, 16'd0, "zero");
        @(negedge clk);
        do_mul(8'd13, 8'd11, 16'd143, "m13x11");
        @(negedge clk);
        do_mul(8'd255, 8'd255, 16'hFE01, "m255x255");
        do_mul(8'd128, 8'd2, 16'd256, "m128x2");
        @(negedge clk);

        // Back-to-back with start held high; next operands presented during DONE.
        bus.a     = 8'd7;
        bus.b     = 8'd6;
        bus.start = 1'b1;
        n = 0;
        while (n < 20 && !bus.done) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_first", int'(bus.product), 42);
        exp_dones++;
        bus.a = 8'd200;
        bus.b = 8'd3;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < 20 && !bus.done);
        chk("b2b_spacing", n, 9);
        chk("b2b_second", int'(bus.product), 600);
        exp_dones++;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);

        // Abort in flight: reset mid-run discards the result and suppresses done.
        bus.a     = 8'd100;
        bus.b     = 8'd100;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_product", int'(bus.product), 0);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        do_mul(8'd15, 8'd17, 16'd255, "m15x17");

        for (int i = 0; i < 1000; i++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_mul(x, y, 16'(x) * 16'(y), "rand");
        end
        repeat (3) @(negedge clk);
        chk("done_count", dut_dones, exp_dones);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
